// File: rtl/multiword_add_sequencer_pkg.sv
// Shared types and defaults for the multi-word add/subtract sequencer.
package multiword_add_sequencer_pkg;

  localparam int unsigned MWAS_WIDTH     = 32;
  localparam int unsigned MWAS_MAX_WORDS = 8;

  // Operation state on the input side.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } seq_state_t;

  // One word held between acceptance and the adder.
  typedef struct packed {
    logic [MWAS_WIDTH-1:0] a;
    logic [MWAS_WIDTH-1:0] b;
    logic                  sub;
    logic                  first;
    logic                  last;
  } stage_t;

  // Signed overflow: the carry into the MSB is sum^a^b at that bit.
  // Overflow is that carry XOR the carry out of the MSB.
  function automatic logic signed_ovf(input logic cout, input logic sum_msb,
                                      input logic a_msb, input logic b_msb);
    return cout ^ (sum_msb ^ a_msb ^ b_msb);
  endfunction

endpackage

// File: rtl/multiword_add_sequencer.sv
// Streams wide add/subtract operations through an external 32-bit adder,
// least-significant word first, chaining the carry between words.
module multiword_add_sequencer
  import multiword_add_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH     = MWAS_WIDTH,
  parameter int unsigned MAX_WORDS = MWAS_MAX_WORDS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_last,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_last,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             err_len
);

  localparam int unsigned CW = $clog2(MAX_WORDS) + 1;

  seq_state_t       state_r, state_nxt_s;
  logic [CW-1:0]    cnt_r, cnt_nxt_s;
  logic             mode_r;
  stage_t           stage_r;
  logic             stage_valid_r;
  logic             carry_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] out_sum_r;
  logic             out_last_r;
  logic             out_cout_r;
  logic             out_ovf_r;
  logic             err_len_r;

  logic             adv_s;
  logic             in_ready_s;
  logic             accept_s;
  logic             first_s;
  logic             sub_eff_s;
  logic             at_max_s;
  logic             last_eff_s;
  logic             force_s;

  // Handshake, word position and effective mode/last for the incoming word.
  always_comb begin
    adv_s      = stage_valid_r && (!out_valid_r || out_ready);
    in_ready_s = !rst && (!stage_valid_r || adv_s);
    accept_s   = in_valid && in_ready_s;
    first_s    = (state_r == IDLE);
    if (first_s) begin
      sub_eff_s = in_sub;
      cnt_nxt_s = CW'(1);
    end else begin
      sub_eff_s = mode_r;
      cnt_nxt_s = cnt_r + CW'(1);
    end
    at_max_s   = (cnt_nxt_s == CW'(MAX_WORDS));
    last_eff_s = in_last || at_max_s;
    force_s    = accept_s && at_max_s && !in_last;
  end

  // Next-state logic: an operation opens on a non-last word and closes on the
  // last word or when the word limit is reached.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s && !last_eff_s) state_nxt_s = RUN;
        else                         state_nxt_s = IDLE;
      end
      RUN: begin
        if (accept_s && last_eff_s) state_nxt_s = IDLE;
        else                        state_nxt_s = RUN;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register, word counter and per-operation mode latch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      mode_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        cnt_r <= last_eff_s ? '0 : cnt_nxt_s;
        if (first_s) mode_r <= in_sub;
      end
    end
  end

  // Stage register: captures an accepted word, B already conditioned for mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid_r <= 1'b0;
      stage_r       <= '0;
    end else if (accept_s) begin
      stage_valid_r <= 1'b1;
      stage_r       <= '{a:     in_a,
                         b:     in_b ^ {WIDTH{sub_eff_s}},
                         sub:   sub_eff_s,
                         first: first_s,
                         last:  last_eff_s};
    end else if (adv_s) begin
      stage_valid_r <= 1'b0;
    end
  end

  // Result capture and carry chaining when the staged word advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= '0;
      out_last_r  <= 1'b0;
      out_cout_r  <= 1'b0;
      out_ovf_r   <= 1'b0;
      carry_r     <= 1'b0;
    end else if (adv_s) begin
      out_valid_r <= 1'b1;
      out_sum_r   <= add_sum;
      out_last_r  <= stage_r.last;
      carry_r     <= add_cout;
      if (stage_r.last) begin
        out_cout_r <= add_cout;
        out_ovf_r  <= signed_ovf(add_cout, add_sum[WIDTH-1],
                                 stage_r.a[WIDTH-1], stage_r.b[WIDTH-1]);
      end
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Sticky flag for operations closed by the word limit.
  always_ff @(posedge clk) begin
    if (rst)          err_len_r <= 1'b0;
    else if (force_s) err_len_r <= 1'b1;
  end

  assign in_ready  = in_ready_s;
  assign add_a     = stage_r.a;
  assign add_b     = stage_r.b;
  assign add_cin   = stage_r.first ? stage_r.sub : carry_r;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_last  = out_last_r;
  assign out_cout  = out_cout_r;
  assign out_ovf   = out_ovf_r;
  assign err_len   = err_len_r;

endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed bench for multiword_add_sequencer with a behavioural sibling adder.
module tb_multiword_add_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_sub;
  logic        in_last;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_last;
  logic        out_cout;
  logic        out_ovf;
  logic        err_len;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] wa [8];
  logic [31:0] wb [8];
  logic        wsub [8];
  logic        wlast [8];
  logic [31:0] es [8];
  logic        el [8];

  multiword_add_sequencer dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sub(in_sub), .in_last(in_last),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_last(out_last),
    .out_cout(out_cout), .out_ovf(out_ovf), .err_len(err_len)
  );

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drives wa/wb/wsub/wlast[0..n-1], optionally stalls the sink, checks es/el.
  task automatic run_stream(input string tag, input int n, input int st_s, input int st_len,
                            input logic ecout, input logic eovf, input logic eerr);
    int          widx = 0;
    int          ridx = 0;
    logic [31:0] h_sum = 32'd0;
    logic        h_last = 1'b0;
    logic        h_valid = 1'b0;
    for (int cyc = 0; cyc < 200 && ridx < n; cyc++) begin
      out_ready = !(cyc >= st_s && cyc < st_s + st_len);
      if (widx < n) begin
        in_valid = 1'b1;
        in_a     = wa[widx];
        in_b     = wb[widx];
        in_sub   = wsub[widx];
        in_last  = wlast[widx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid) begin
        if (h_valid) begin
          chk32({tag, " hold_sum"}, out_sum, h_sum);
          chk1({tag, " hold_last"}, out_last, h_last);
        end
        if (out_ready) begin
          chk32({tag, " sum"}, out_sum, es[ridx]);
          chk1({tag, " last"}, out_last, el[ridx]);
          if (el[ridx]) begin
            chk1({tag, " cout"}, out_cout, ecout);
            chk1({tag, " ovf"}, out_ovf, eovf);
          end
          ridx++;
        end
      end
      h_valid = out_valid && !out_ready;
      h_sum   = out_sum;
      h_last  = out_last;
      if (st_len >= 3 && cyc == st_s + st_len - 1)
        chk1({tag, " in_ready_full"}, in_ready, 1'b0);
      if (in_valid && in_ready) widx++;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk32({tag, " words_out"}, ridx, n);
    chk1({tag, " err_len"}, err_len, eerr);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = 32'd0; in_b = 32'd0;
    in_sub = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick();
    tick();
    chk1("rst in_ready", in_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk1("rst out_valid", out_valid, 1'b0);
    chk1("rst in_ready_after", in_ready, 1'b1);
    chk32("rst out_sum", out_sum, 32'd0);
    chk1("rst out_last", out_last, 1'b0);
    chk1("rst out_cout", out_cout, 1'b0);
    chk1("rst out_ovf", out_ovf, 1'b0);
    chk1("rst err_len", err_len, 1'b0);

    // Single-word add with latency checks.
    in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001;
    in_sub = 1'b0; in_last = 1'b1;
    tick();
    in_valid = 1'b0;
    chk1("t1 lat_not_yet", out_valid, 1'b0);
    tick();
    chk1("t1 out_valid", out_valid, 1'b1);
    chk32("t1 sum", out_sum, 32'h0000_0000);
    chk1("t1 last", out_last, 1'b1);
    chk1("t1 cout", out_cout, 1'b1);
    chk1("t1 ovf", out_ovf, 1'b0);
    tick();
    chk1("t1 drained", out_valid, 1'b0);

    // 64-bit add.
    wa[0] = 32'hFFFF_FFFF; wb[0] = 32'h0000_0001; wsub[0] = 1'b0; wlast[0] = 1'b0;
    wa[1] = 32'h0000_0001; wb[1] = 32'h0000_0000; wsub[1] = 1'b0; wlast[1] = 1'b1;
    es[0] = 32'h0000_0000; el[0] = 1'b0;
    es[1] = 32'h0000_0002; el[1] = 1'b1;
    run_stream("t2", 2, 0, 0, 1'b0, 1'b0, 1'b0);

    // 64-bit subtract; in_sub dropped on word 1 must be ignored.
    wa[0] = 32'h0; wb[0] = 32'h1; wsub[0] = 1'b1; wlast[0] = 1'b0;
    wa[1] = 32'h0; wb[1] = 32'h0; wsub[1] = 1'b0; wlast[1] = 1'b1;
    es[0] = 32'hFFFF_FFFF; el[0] = 1'b0;
    es[1] = 32'hFFFF_FFFF; el[1] = 1'b1;
    run_stream("t3", 2, 0, 0, 1'b0, 1'b0, 1'b0);

    // Signed overflow on a single word.
    wa[0] = 32'h7FFF_FFFF; wb[0] = 32'h0000_0001; wsub[0] = 1'b0; wlast[0] = 1'b1;
    es[0] = 32'h8000_0000; el[0] = 1'b1;
    run_stream("t4", 1, 0, 0, 1'b0, 1'b1, 1'b0);

    // Four-word stream with a 5-cycle sink stall; carry ripples into the top word.
    wa[0] = 32'hFFFF_FFFF; wb[0] = 32'h1; wsub[0] = 1'b0; wlast[0] = 1'b0;
    wa[1] = 32'hFFFF_FFFF; wb[1] = 32'h0; wsub[1] = 1'b0; wlast[1] = 1'b0;
    wa[2] = 32'hFFFF_FFFF; wb[2] = 32'h0; wsub[2] = 1'b0; wlast[2] = 1'b0;
    wa[3] = 32'h7FFF_FFFF; wb[3] = 32'h0; wsub[3] = 1'b0; wlast[3] = 1'b1;
    es[0] = 32'h0; el[0] = 1'b0;
    es[1] = 32'h0; el[1] = 1'b0;
    es[2] = 32'h0; el[2] = 1'b0;
    es[3] = 32'h8000_0000; el[3] = 1'b1;
    run_stream("t5", 4, 1, 5, 1'b0, 1'b1, 1'b0);

    // Eight words without in_last: forced close and sticky error.
    for (int i = 0; i < 8; i++) begin
      wa[i] = i; wb[i] = 32'h1; wsub[i] = 1'b0; wlast[i] = 1'b0;
      es[i] = i + 1; el[i] = (i == 7);
    end
    run_stream("t6", 8, 0, 0, 1'b0, 1'b0, 1'b1);

    // Back in IDLE: the next word starts a fresh subtract.
    wa[0] = 32'd5; wb[0] = 32'd3; wsub[0] = 1'b1; wlast[0] = 1'b1;
    es[0] = 32'd2; el[0] = 1'b1;
    run_stream("t6b", 1, 0, 0, 1'b1, 1'b0, 1'b1);

    // Reset mid-stream with stage and output occupied.
    in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1; in_sub = 1'b0; in_last = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    tick();
    chk1("t7 pre_rst out_valid", out_valid, 1'b1);
    rst = 1'b1;
    #1;
    chk1("t7 rst in_ready", in_ready, 1'b0);
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk1("t7 out_valid", out_valid, 1'b0);
    chk1("t7 in_ready", in_ready, 1'b1);
    chk1("t7 err_len", err_len, 1'b0);
    chk32("t7 out_sum", out_sum, 32'd0);

    wa[0] = 32'h0; wb[0] = 32'h1; wsub[0] = 1'b1; wlast[0] = 1'b0;
    wa[1] = 32'h0; wb[1] = 32'h0; wsub[1] = 1'b0; wlast[1] = 1'b1;
    es[0] = 32'hFFFF_FFFF; el[0] = 1'b0;
    es[1] = 32'hFFFF_FFFF; el[1] = 1'b1;
    run_stream("t7b", 2, 0, 0, 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
